// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, PC step and buffer entry layout for the fetch stage.
package fetch_pkg;
   localparam int PC_W = 32;
   localparam int PC_STEP = 4;
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HALT    = 2'd2
   } state_t;
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     word;
   } entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched {pc, word} entries with single-cycle flush.
module fetch_buffer import fetch_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  entry_t        data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic          valid,
   output entry_t        head
);
   entry_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic take;

   assign valid = count != '0;
   assign take = pop & valid;
   assign head = mem[rd];

   always_ff @(posedge clk)
      if (!rst_n) begin
         mem <= '{default: '0};
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else if (flush) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr] <= data;
            wr <= wr + AW'(1);
         end
         if (take) rd <= rd + AW'(1);
         count <= count + CW'(push) - CW'(take);
      end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS fetch stage; owns the PC, reads memory over req/ack, buffers words for the decoder.
// Define FETCH_ALIGN_CHECK_EN to fault and halt on misaligned redirect targets.
module fetch_unit import fetch_pkg::*; #(
   parameter int                  PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter int                  BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                instr_valid,
   output logic [31:0]         instr,
   output logic [PC_WIDTH-1:0] instr_pc,
   input  logic                instr_ready,
   output logic                fault
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   state_t state, state_n;
   logic [PC_WIDTH-1:0] fetch_pc, pc_n, target, addr_n;
   logic [CW-1:0] count, count_n;
   logic ack, pop, push, redir, hold, bad, req_n;
   entry_t head, in_entry;

   assign ack = imem_req & imem_ack;
   assign pop = instr_valid & instr_ready;
   assign redir = redirect & (state != HALT);
   assign in_entry = '{pc: PC_W'(fetch_pc), word: imem_rdata};
   assign instr = head.word;
   assign instr_pc = PC_WIDTH'(head.pc);

`ifdef FETCH_ALIGN_CHECK_EN
   assign target = redirect_pc;
   assign bad = redir & (redirect_pc[1:0] != 2'b00);
   always_ff @(posedge clk)
      if (!rst_n) fault <= 1'b0;
      else if (bad) fault <= 1'b1;
`else
   assign target = redirect_pc & ~PC_WIDTH'(3);
   assign bad = 1'b0;
   assign fault = 1'b0;
`endif

   // An un-acked request must complete before anything new issues; its data is dropped after a redirect.
   always_comb begin
      hold = imem_req & ~ack;
      push = ack & (state == FETCH) & ~redir;
      pc_n = redir ? target : (push ? fetch_pc + PC_WIDTH'(PC_STEP) : fetch_pc);
      count_n = redir ? '0 : count + CW'(push) - CW'(pop);
      state_n = (state == HALT || ((bad || fault) && !hold)) ? HALT :
                (hold && (redir || state == DISCARD)) ? DISCARD : FETCH;
      req_n = hold || (state_n == FETCH && count_n < CW'(BUF_DEPTH));
      addr_n = hold ? imem_addr : pc_n;
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= FETCH;
         fetch_pc <= RESET_PC;
         imem_req <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state <= state_n;
         fetch_pc <= pc_n;
         imem_req <= req_n;
         imem_addr <= addr_n;
      end

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .data  (in_entry),
      .pop   (pop),
      .flush (redir),
      .count (count),
      .valid (instr_valid),
      .head  (head)
   );
endmodule
